alu_input_loader: RTL and testbench

- Front-end stage that feeds the ALU. It debounces three push-buttons and latches the board switches into operando_A, operando_B or cod_operacion.
- Rejects opcodes outside the supported set.
- Registers the ALU's combinational result onto the LEDs once all three operands are loaded.
- Sits between board I/O (switches, buttons, LEDs) and the ALU instance.

---
 rtl/alu_pkg.sv | 31 +++
 rtl/alu_input_loader_debouncer.sv | 59 +++++
 rtl/alu_input_loader.sv | 133 +++++++++++++
 tb/tb_alu_input_loader.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: default widths, opcodes and opcode check.
// Used by the input loader, the ALU and their benches.
package alu_pkg;

  localparam int NBITS_DEF  = 8;
  localparam int COD_OP_DEF = 6;

  localparam logic [5:0] OP_ADD = 6'b100000;
  localparam logic [5:0] OP_SUB = 6'b100010;
  localparam logic [5:0] OP_AND = 6'b100100;
  localparam logic [5:0] OP_OR  = 6'b100101;
  localparam logic [5:0] OP_XOR = 6'b100110;
  localparam logic [5:0] OP_SRA = 6'b000011;
  localparam logic [5:0] OP_SRL = 6'b000010;
  localparam logic [5:0] OP_NOR = 6'b100111;

  function automatic logic is_valid_op(
    input logic [5:0] op
  );
    logic ok;
    ok = 1'b0;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_XOR, OP_SRA, OP_SRL, OP_NOR:
        ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/alu_input_loader_debouncer.sv
// Button debouncer: 2-FF sync, stability counter, rising pulse.
// Ports: clk, reset, btn_i (raw), pulse_o (1 cycle per press).
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  output logic pulse_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_MAX =
    CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q;
  logic          sync2_q;
  logic          stable_q;
  logic          stable_d;
  logic          prev_q;
  logic          pulse_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Counter only runs while the synced level disagrees
  // with the accepted level, so it stops at CNT_MAX.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_MAX) begin
        stable_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      prev_q   <= 1'b0;
      pulse_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= btn_i;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      prev_q   <= stable_q;
      pulse_q  <= stable_q & ~prev_q;
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/alu_input_loader.sv
// ALU front end: debounced buttons latch switches into
// A, B and opcode; result is registered onto the LEDs.
// Ports: clk, reset, i_switches, i_btn_a/b/op, ALU_Result
// in; operando_A/B, cod_operacion, o_loaded, o_op_error,
// o_leds out.
module alu_input_loader
  import alu_pkg::*;
#(
  parameter int NBITS           = NBITS_DEF,
  parameter int COD_OP          = COD_OP_DEF,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NBITS-1:0]  i_switches,
  input  logic              i_btn_a,
  input  logic              i_btn_b,
  input  logic              i_btn_op,
  input  logic [NBITS-1:0]  ALU_Result,
  output logic [NBITS-1:0]  operando_A,
  output logic [NBITS-1:0]  operando_B,
  output logic [COD_OP-1:0] cod_operacion,
  output logic [2:0]        o_loaded,
  output logic              o_op_error,
  output logic [NBITS-1:0]  o_leds
);

  logic              pa;
  logic              pb;
  logic              pop;
  logic [COD_OP-1:0] sw_op;
  logic              op_ok;

  logic [NBITS-1:0]  a_q, a_d;
  logic [NBITS-1:0]  b_q, b_d;
  logic [COD_OP-1:0] op_q, op_d;
  logic [2:0]        ld_q, ld_d;
  logic              err_q, err_d;
  logic [NBITS-1:0]  leds_q, leds_d;
  logic              cap_q, cap_d;

  button_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_db_a (
    .clk    (clk),
    .reset  (reset),
    .btn_i  (i_btn_a),
    .pulse_o(pa)
  );

  button_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_db_b (
    .clk    (clk),
    .reset  (reset),
    .btn_i  (i_btn_b),
    .pulse_o(pb)
  );

  button_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_db_op (
    .clk    (clk),
    .reset  (reset),
    .btn_i  (i_btn_op),
    .pulse_o(pop)
  );

  assign sw_op = i_switches[COD_OP-1:0];
  assign op_ok = is_valid_op(6'(sw_op));

  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    op_d   = op_q;
    ld_d   = ld_q;
    err_d  = err_q;
    leds_d = leds_q;
    cap_d  = 1'b0;
    if (pa) begin
      a_d     = i_switches;
      ld_d[0] = 1'b1;
    end
    if (pb) begin
      b_d     = i_switches;
      ld_d[1] = 1'b1;
    end
    if (pop) begin
      if (op_ok) begin
        op_d    = sw_op;
        ld_d[2] = 1'b1;
        err_d   = 1'b0;
      end else begin
        err_d = 1'b1;
      end
    end
    // Capture one cycle late so the ALU sees the
    // new operands before the result is sampled.
    cap_d = (pa | pb | (pop & op_ok)) &
            (ld_d == 3'b111);
    if (cap_q) begin
      leds_d = ALU_Result;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q    <= '0;
      b_q    <= '0;
      op_q   <= COD_OP'(OP_ADD);
      ld_q   <= 3'b000;
      err_q  <= 1'b0;
      leds_q <= '0;
      cap_q  <= 1'b0;
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      op_q   <= op_d;
      ld_q   <= ld_d;
      err_q  <= err_d;
      leds_q <= leds_d;
      cap_q  <= cap_d;
    end
  end

  assign operando_A    = a_q;
  assign operando_B    = b_q;
  assign cod_operacion = op_q;
  assign o_loaded      = ld_q;
  assign o_op_error    = err_q;
  assign o_leds        = leds_q;

endmodule

// File: tb/tb_alu_input_loader.sv
// Bench for alu_input_loader with a behavioural ALU
// and a queue of expected output states.
module tb_alu_input_loader;
  import alu_pkg::*;

  typedef struct packed {
    logic       err;
    logic [2:0] ld;
    logic [5:0] op;
    logic [7:0] leds;
    logic [7:0] b;
    logic [7:0] a;
  } st_t;

  logic       clk;
  logic       reset;
  logic [7:0] i_switches;
  logic       i_btn_a;
  logic       i_btn_b;
  logic       i_btn_op;
  logic [7:0] ALU_Result;
  logic [7:0] operando_A;
  logic [7:0] operando_B;
  logic [5:0] cod_operacion;
  logic [2:0] o_loaded;
  logic       o_op_error;
  logic [7:0] o_leds;

  int   checks;
  int   failures;
  st_t  sb[$];
  st_t  model;
  st_t  rst_st;
  st_t  snap[12];
  st_t  e;
  st_t  got;

  alu_input_loader #(
    .NBITS(8),
    .COD_OP(6),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .i_switches   (i_switches),
    .i_btn_a      (i_btn_a),
    .i_btn_b      (i_btn_b),
    .i_btn_op     (i_btn_op),
    .ALU_Result   (ALU_Result),
    .operando_A   (operando_A),
    .operando_B   (operando_B),
    .cod_operacion(cod_operacion),
    .o_loaded     (o_loaded),
    .o_op_error   (o_op_error),
    .o_leds       (o_leds)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU standing in for the real one.
  always_comb begin
    ALU_Result = 8'h00;
    case (cod_operacion)
      OP_ADD: ALU_Result = operando_A + operando_B;
      OP_SUB: ALU_Result = operando_A - operando_B;
      OP_AND: ALU_Result = operando_A & operando_B;
      OP_OR:  ALU_Result = operando_A | operando_B;
      OP_XOR: ALU_Result = operando_A ^ operando_B;
      OP_SRA: ALU_Result =
        $signed(operando_A) >>> operando_B;
      OP_SRL: ALU_Result = operando_A >> operando_B;
      OP_NOR: ALU_Result = ~(operando_A | operando_B);
      default: ALU_Result = 8'h00;
    endcase
  end

  function automatic st_t cur();
    return {o_op_error, o_loaded, cod_operacion,
            o_leds, operando_B, operando_A};
  endfunction

  // Hold buttons 12 cycles; snap[k] is the state after
  // edge E0+k. Switches flip after the load so any
  // extra pulse would be visible.
  task automatic press(
    input logic [2:0] btn,
    input logic [7:0] sw
  );
    @(negedge clk);
    i_switches = sw;
    {i_btn_op, i_btn_b, i_btn_a} = btn;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      snap[k] = cur();
      if (k == 8) i_switches = ~sw;
    end
    {i_btn_op, i_btn_b, i_btn_a} = 3'b000;
    repeat (12) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    model = rst_st;
    sb.push_back(model);
    repeat (3) @(negedge clk);
    e = sb.pop_front();
    got = cur();
    checks++;
    if (got !== e) begin
      failures++;
      $display("FAIL reset got=%h exp=%h", got, e);
    end
  endtask

  task automatic test_load_a();
    model.a = 8'd25;
    model.ld[0] = 1'b1;
    sb.push_back(model);
    press(3'b001, 8'd25);
    checks++;
    if (snap[6].a !== 8'd0) begin
      failures++;
      $display("FAIL a_early got=%0d exp=0",
               snap[6].a);
    end
    checks++;
    if (snap[7].a !== 8'd25 ||
        snap[7].ld !== 3'b001) begin
      failures++;
      $display("FAIL a_edge7 got=%0d/%b exp=25/001",
               snap[7].a, snap[7].ld);
    end
    e = sb.pop_front();
    got = cur();
    checks++;
    if (got !== e) begin
      failures++;
      $display("FAIL load_a got=%h exp=%h", got, e);
    end
  endtask

  task automatic test_glitch_b();
    sb.push_back(model);
    @(negedge clk);
    i_switches = 8'd77;
    for (int i = 0; i < 10; i++) begin
      i_btn_b = ~i_btn_b;
      repeat (2) @(negedge clk);
    end
    i_btn_b = 1'b0;
    repeat (12) @(negedge clk);
    e = sb.pop_front();
    got = cur();
    checks++;
    if (got !== e) begin
      failures++;
      $display("FAIL glitch_b got=%h exp=%h", got, e);
    end
  endtask

  task automatic test_capture();
    model.b = 8'd17;
    model.ld[1] = 1'b1;
    sb.push_back(model);
    press(3'b010, 8'd17);
    e = sb.pop_front();
    got = cur();
    checks++;
    if (got !== e) begin
      failures++;
      $display("FAIL load_b got=%h exp=%h", got, e);
    end
    model.op = OP_ADD;
    model.ld = 3'b111;
    model.leds = 8'd42;
    sb.push_back(model);
    press(3'b100, 8'b00100000);
    checks++;
    if (snap[7].ld !== 3'b111 ||
        snap[7].leds !== 8'd0) begin
      failures++;
      $display("FAIL cap_e7 got=%b/%0d exp=111/0",
               snap[7].ld, snap[7].leds);
    end
    checks++;
    if (snap[8].leds !== 8'd42) begin
      failures++;
      $display("FAIL cap_e8 got=%0d exp=42",
               snap[8].leds);
    end
    e = sb.pop_front();
    got = cur();
    checks++;
    if (got !== e) begin
      failures++;
      $display("FAIL add got=%h exp=%h", got, e);
    end
  endtask

  task automatic test_op_error();
    model.err = 1'b1;
    sb.push_back(model);
    press(3'b100, 8'b00111111);
    checks++;
    if (snap[7].err !== 1'b1) begin
      failures++;
      $display("FAIL err_e7 got=%b exp=1",
               snap[7].err);
    end
    e = sb.pop_front();
    got = cur();
    checks++;
    if (got !== e) begin
      failures++;
      $display("FAIL bad_op got=%h exp=%h", got, e);
    end
    model.err = 1'b0;
    model.op = OP_SUB;
    model.leds = 8'd8;
    sb.push_back(model);
    press(3'b100, 8'b00100010);
    checks++;
    if (snap[7].leds !== 8'd42 ||
        snap[8].leds !== 8'd8) begin
      failures++;
      $display("FAIL sub_cap got=%0d,%0d exp=42,8",
               snap[7].leds, snap[8].leds);
    end
    e = sb.pop_front();
    got = cur();
    checks++;
    if (got !== e) begin
      failures++;
      $display("FAIL sub got=%h exp=%h", got, e);
    end
  endtask

  task automatic test_simul_reset();
    model.a = 8'd9;
    model.b = 8'd9;
    model.leds = 8'd0;
    sb.push_back(model);
    press(3'b011, 8'd9);
    checks++;
    if (snap[7].a !== 8'd9 ||
        snap[7].b !== 8'd9) begin
      failures++;
      $display("FAIL ab_e7 got=%0d/%0d exp=9/9",
               snap[7].a, snap[7].b);
    end
    e = sb.pop_front();
    got = cur();
    checks++;
    if (got !== e) begin
      failures++;
      $display("FAIL ab_same got=%h exp=%h", got, e);
    end
    model = rst_st;
    sb.push_back(model);
    @(negedge clk);
    i_switches = 8'b00100100;
    i_btn_op = 1'b1;
    repeat (4) @(negedge clk);
    #2;
    reset = 1'b1;
    i_btn_op = 1'b0;
    #1;
    got = cur();
    checks++;
    if (got !== rst_st) begin
      failures++;
      $display("FAIL async_rst got=%h exp=%h",
               got, rst_st);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (15) @(negedge clk);
    e = sb.pop_front();
    got = cur();
    checks++;
    if (got !== e) begin
      failures++;
      $display("FAIL post_rst got=%h exp=%h", got, e);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b1;
    i_switches = 8'd0;
    i_btn_a = 1'b0;
    i_btn_b = 1'b0;
    i_btn_op = 1'b0;
    rst_st = {1'b0, 3'b000, OP_ADD,
              8'd0, 8'd0, 8'd0};
    model = rst_st;
    test_reset();
    test_load_a();
    test_glitch_b();
    test_capture();
    test_op_error();
    test_simul_reset();
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
